// File: rtl/mnist_window_gen_pkg.sv
// Shared geometry, FSM encoding and IMGIN packing helpers for the MNIST window generator.
package mnist_window_gen_pkg;
    localparam int IMG_W    = 28;                 // square image edge
    localparam int K        = 5;                  // window edge
    localparam int OUT_W    = IMG_W - K + 1;      // window positions per axis
    localparam int PW       = 8;                  // pixel width
    localparam int WIN_BITS = K * K * PW;         // flattened window width
    localparam int CW       = 5;                  // col / X / Y counter width
    localparam int SW       = 3;                  // ring slot index width

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // LSB of window element (row i, column j) inside IMGIN
    function automatic int imgin_lsb(input int i, input int j);
        return (i * K + j) * PW;
    endfunction

    // (base + i) mod K for ring slot lookup, i in 0..K-1
    function automatic logic [SW-1:0] slot_add(input logic [SW-1:0] base, input int i);
        logic [SW:0] s;
        s = {1'b0, base} + (SW+1)'(i);
        if (s >= (SW+1)'(K))
            s = s - (SW+1)'(K);
        return s[SW-1:0];
    endfunction
endpackage

// File: rtl/mnist_window_gen_if.sv
// Pixel-stream input and window/handshake output bundle of the window generator.
interface mnist_window_gen_if;
    logic [mnist_window_gen_pkg::PW-1:0]       PIX_IN;
    logic                                      PIX_VALID;
    logic                                      PIX_READY;
    logic                                      START;
    logic [mnist_window_gen_pkg::CW-1:0]       X;
    logic [mnist_window_gen_pkg::CW-1:0]       Y;
    logic [mnist_window_gen_pkg::WIN_BITS-1:0] IMGIN;
    logic                                      DONE;
    logic                                      FRAME_DONE;
    logic                                      ERR;

    // generator side
    modport slave (
        input  PIX_IN, PIX_VALID, DONE,
        output PIX_READY, START, X, Y, IMGIN, FRAME_DONE, ERR
    );

    // pixel source / CNN side
    modport master (
        output PIX_IN, PIX_VALID, DONE,
        input  PIX_READY, START, X, Y, IMGIN, FRAME_DONE, ERR
    );
endinterface

// File: rtl/mnist_window_gen_line_buf.sv
// K-row ring buffer of IMG_W pixels with one write port and a full KxK window read.
module mnist_line_buf
    import mnist_window_gen_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [SW-1:0]       wr_slot,
    input  logic [CW-1:0]       wr_col,
    input  logic [PW-1:0]       wr_data,
    input  logic [SW-1:0]       rd_slot,   // slot holding window row 0
    input  logic [CW-1:0]       rd_col,    // window left column
    output logic [WIN_BITS-1:0] rd_win
);
    logic [PW-1:0] mem [K][IMG_W];

    // store accepted pixels; contents need no reset, every slot is rewritten before use
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_slot][wr_col] <= wr_data;
    end

    // gather the window: row i comes from slot (rd_slot + i) mod K
    always_comb begin
        rd_win = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                rd_win[imgin_lsb(i, j) +: PW] = mem[slot_add(rd_slot, i)][rd_col + CW'(j)];
    end
endmodule

// File: rtl/mnist_window_gen.sv
// Streams 28x28 MNIST frames into a 5-row ring and issues all 24x24 5x5 windows,
// one per CNN DONE rising edge. Optional DONE watchdog enabled by WINGEN_TIMEOUT_EN.
module mnist_window_gen
    import mnist_window_gen_pkg::*;
#(
    parameter int TIMEOUT = 1024
)(
    input  logic               CLK,
    input  logic               RST,
    mnist_window_gen_if.slave  bus
);
    logic [1:0]          state;
    logic [CW-1:0]       col, x_cnt, y_cnt;
    logic [2:0]          rows_needed;
    logic [SW-1:0]       wr_slot, base_slot;
    logic                done_q;
    logic [WIN_BITS-1:0] win;

    logic                start_r, frame_done_r, err_r;
    logic [CW-1:0]       x_r, y_r;
    logic [WIN_BITS-1:0] imgin_r;

    logic accept, done_edge, tmo, advance;

    assign bus.PIX_READY  = (state == ST_FILL) && !RST;
    assign bus.START      = start_r;
    assign bus.X          = x_r;
    assign bus.Y          = y_r;
    assign bus.IMGIN      = imgin_r;
    assign bus.FRAME_DONE = frame_done_r;
    assign bus.ERR        = err_r;

    assign accept    = bus.PIX_VALID && bus.PIX_READY;
    // an edge coinciding with START belongs to the previous window and is dropped
    assign done_edge = bus.DONE && !done_q && !start_r;
    assign advance   = (state == ST_WAIT) && (done_edge || tmo);

`ifdef WINGEN_TIMEOUT_EN
    logic [10:0] tmo_cnt;

    // watchdog: zero while START is up, then counts every WAIT cycle
    always_ff @(posedge CLK) begin
        if (RST)
            tmo_cnt <= '0;
        else if (state == ST_ISSUE)
            tmo_cnt <= '0;
        else if (state == ST_WAIT && !advance)
            tmo_cnt <= tmo_cnt + 11'd1;
    end

    assign tmo = (state == ST_WAIT) && (tmo_cnt == 11'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    mnist_line_buf u_line_buf (
        .clk     (CLK),
        .wr_en   (accept),
        .wr_slot (wr_slot),
        .wr_col  (col),
        .wr_data (bus.PIX_IN),
        .rd_slot (base_slot),
        .rd_col  (y_cnt),
        .rd_win  (win)
    );

    // FSM: fill needed rows, issue a window, wait for DONE, step Y then X
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_FILL;
            col          <= '0;
            x_cnt        <= '0;
            y_cnt        <= '0;
            rows_needed  <= 3'(K);
            wr_slot      <= '0;
            base_slot    <= '0;
            done_q       <= 1'b0;
            start_r      <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            x_r          <= '0;
            y_r          <= '0;
            imgin_r      <= '0;
        end else begin
            done_q       <= bus.DONE;
            start_r      <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        if (col == CW'(IMG_W - 1)) begin
                            col         <= '0;
                            rows_needed <= rows_needed - 3'd1;
                            wr_slot     <= (wr_slot == SW'(K - 1)) ? '0 : wr_slot + SW'(1);
                            if (rows_needed == 3'd1)
                                state <= ST_ISSUE;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    imgin_r <= win;
                    x_r     <= x_cnt;
                    y_r     <= y_cnt;
                    start_r <= 1'b1;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (advance) begin
                        err_r <= tmo && !done_edge;
                        if (y_cnt != CW'(OUT_W - 1)) begin
                            y_cnt <= y_cnt + CW'(1);
                            state <= ST_ISSUE;
                        end else if (x_cnt != CW'(OUT_W - 1)) begin
                            // slide down one row: the oldest slot is overwritten
                            y_cnt       <= '0;
                            x_cnt       <= x_cnt + CW'(1);
                            base_slot   <= (base_slot == SW'(K - 1)) ? '0 : base_slot + SW'(1);
                            rows_needed <= 3'd1;
                            state       <= ST_FILL;
                        end else begin
                            frame_done_r <= 1'b1;
                            x_cnt        <= '0;
                            y_cnt        <= '0;
                            x_r          <= '0;
                            y_r          <= '0;
                            base_slot    <= '0;
                            wr_slot      <= '0;
                            rows_needed  <= 3'(K);
                            state        <= ST_FILL;
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_mnist_window_gen.sv
// Self-checking bench for mnist_window_gen: frame streaming with a window-level reference model.
module tb_mnist_window_gen;
    logic clk;
    logic rst;

    mnist_window_gen_if bus ();

    mnist_window_gen #(.TIMEOUT(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   img [28][28];
    int           pix_ptr, win_cnt, acc_since, cyc;
    int           last_start_cyc, last_acc_cyc, last_rise_cyc;
    int           gap_pct, fd_cnt, err_seen, err_cyc;
    bit           pending, auto_done, lat_chk, allow_err;
    logic [199:0] first_win, last_win;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // window (x,y): element (i,j) is image pixel (x+i, y+j)
    function automatic logic [199:0] exp_win(input int x, input int y);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*8 +: 8] = img[x+i][y+j];
        return w;
    endfunction

    task automatic new_frame(input int kind);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = (kind == 0) ? 8'((r*28 + c) & 255) : 8'hAA;
        pix_ptr = 0; win_cnt = 0; acc_since = 0; fd_cnt = 0;
    endtask

    // one clock: observe outputs of this cycle, then drive inputs for it
    task automatic step();
        int ex, ey, lat_ref;
        @(posedge clk); #1;
        cyc++;
        if (bus.START) begin
            ex = win_cnt / 24;
            ey = win_cnt % 24;
            chk("x", bus.X, ex);
            chk("y", bus.Y, ey);
            chk("imgin", bus.IMGIN, exp_win(ex, ey));
            chk("pixels_per_start", acc_since, (ex == 0 && ey == 0) ? 140 : ((ey == 0) ? 28 : 0));
            lat_ref = (last_acc_cyc > last_rise_cyc) ? last_acc_cyc : last_rise_cyc;
            if (lat_chk) chk("start_latency", cyc, lat_ref + 2);
            if (win_cnt == 0) first_win = bus.IMGIN;
            last_win = bus.IMGIN;
            win_cnt++; acc_since = 0; pending = 1'b1; last_start_cyc = cyc;
        end
        if (bus.FRAME_DONE) begin
            fd_cnt++;
            chk("fd_after_done", cyc - last_rise_cyc, 1);
            chk("fd_windows", win_cnt, 576);
            chk("fd_x_zero", bus.X, 0);
            chk("fd_y_zero", bus.Y, 0);
        end
        if (bus.ERR) begin err_seen++; err_cyc = cyc; end
        if (!allow_err) chk("err_quiet", bus.ERR, 0);
        if (pending) chk("ready_low_wait", bus.PIX_READY, 0);
        if (auto_done) begin
            if (pending && (cyc - last_start_cyc) >= 3 && !bus.DONE) begin
                bus.DONE = 1'b1; pending = 1'b0; last_rise_cyc = cyc;
            end else begin
                bus.DONE = 1'b0;
            end
        end
        if (pix_ptr < 784 && $urandom_range(99) >= gap_pct) begin
            bus.PIX_VALID = 1'b1;
            bus.PIX_IN    = img[pix_ptr/28][pix_ptr%28];
        end else begin
            bus.PIX_VALID = 1'b0;
            bus.PIX_IN    = 8'($urandom);
        end
        if (bus.PIX_VALID && bus.PIX_READY) begin
            pix_ptr++; acc_since++; last_acc_cyc = cyc;
        end
    endtask

    task automatic run_to(input int n);
        for (int k = 0; k < 20000 && win_cnt < n; k++) step();
        chk("reach_windows", win_cnt, n);
    endtask

    task automatic run_fd();
        int f0;
        f0 = fd_cnt;
        for (int k = 0; k < 30000 && fd_cnt == f0; k++) step();
        repeat (3) step();
        chk("frame_done_once", fd_cnt, f0 + 1);
    endtask

    initial begin
        int s, w0;
        rst = 1'b1; cyc = 0; pending = 0; auto_done = 1; lat_chk = 1; allow_err = 0;
        gap_pct = 0; err_seen = 0; err_cyc = 0;
        last_start_cyc = 0; last_acc_cyc = 0; last_rise_cyc = 0;
        bus.PIX_IN = '0; bus.PIX_VALID = 1'b0; bus.DONE = 1'b0;
        new_frame(0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", bus.START, 0);
        chk("rst_x", bus.X, 0);
        chk("rst_y", bus.Y, 0);
        chk("rst_imgin", bus.IMGIN, 0);
        chk("rst_frame_done", bus.FRAME_DONE, 0);
        chk("rst_err", bus.ERR, 0);
        chk("rst_ready", bus.PIX_READY, 0);
        rst = 1'b0;

        // full ramp frame, no gaps, DONE 3 cycles after START
        run_fd();
        chk("first_b0", first_win[7:0], 8'h00);
        chk("first_b1", first_win[15:8], 8'h01);
        chk("first_b4", first_win[39:32], 8'h04);
        chk("first_b5", first_win[47:40], 8'h1C);
        chk("last_b0", last_win[7:0], 8'h9B);
        chk("last_b24", last_win[199:192], 8'h0F);
        chk("post_frame_x", bus.X, 0);
        chk("post_frame_y", bus.Y, 0);

        // same frame with random PIX_VALID gaps; DONE held high for one window
        new_frame(0);
        gap_pct = 40;
        run_to(1);
        auto_done = 0;
        step();
        bus.DONE = 1'b1; pending = 1'b0; last_rise_cyc = cyc;
        w0 = win_cnt;
        repeat (10) step();
        bus.DONE = 1'b0;
        repeat (4) step();
        chk("held_done_single", win_cnt - w0, 1);
        chk("held_done_y", bus.Y, 1);
        chk("held_done_x", bus.X, 0);
        auto_done = 1;
        run_fd();

        // reset in the middle of window (10,5), then a flat 0xAA frame
        new_frame(0);
        gap_pct = 10;
        run_to(246);
        chk("pre_rst_x", bus.X, 10);
        chk("pre_rst_y", bus.Y, 5);
        bus.DONE = 1'b0; bus.PIX_VALID = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        cyc++;
        chk("mid_rst_start", bus.START, 0);
        chk("mid_rst_x", bus.X, 0);
        chk("mid_rst_y", bus.Y, 0);
        chk("mid_rst_imgin", bus.IMGIN, 0);
        chk("mid_rst_fd", bus.FRAME_DONE, 0);
        chk("mid_rst_err", bus.ERR, 0);
        chk("mid_rst_ready", bus.PIX_READY, 0);
        rst = 1'b0;
        pending = 1'b0;
        new_frame(1);
        run_to(1);
        chk("aa_first_imgin", first_win, {25{8'hAA}});
        chk("aa_first_x", bus.X, 0);
        chk("aa_first_y", bus.Y, 0);
        run_fd();

        // DONE never arrives
        new_frame(0);
        gap_pct = 0;
        run_to(1);
        auto_done = 0; lat_chk = 0; bus.DONE = 1'b0;
        s = last_start_cyc; w0 = win_cnt; err_seen = 0;
`ifdef WINGEN_TIMEOUT_EN
        allow_err = 1;
        repeat (20) step();
        chk("tmo_err_count", err_seen, 1);
        chk("tmo_err_offset", err_cyc - s, 16);
        chk("tmo_next_start", win_cnt - w0, 1);
        chk("tmo_start_offset", last_start_cyc - s, 17);
        chk("tmo_y", bus.Y, 1);
`else
        repeat (60) step();
        chk("no_tmo_start", win_cnt - w0, 0);
        chk("no_tmo_err", err_seen, 0);
        chk("no_tmo_y", bus.Y, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
